// File: rtl/riscv_core_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating PHT, zero-latency lookup, update from execute.
// Optional gshare indexing of the PHT is enabled by defining BP_GSHARE_EN.
module riscv_core_branch_predictor #(
    parameter int ALEN    = 64,
    parameter int ENTRIES = 16,
    localparam int IDX    = $clog2(ENTRIES),
    localparam int TW     = ALEN - IDX - 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [ALEN-1:0] i_fetch_pc,
    output logic            o_valid,
    output logic            o_branch_taken,
    output logic [ALEN-1:0] o_target_address,
    input  logic            i_ex_valid,
    input  logic            i_ex_branch,
    input  logic            i_ex_jump,
    input  logic [ALEN-1:0] i_ex_pc,
    input  logic            i_ex_is_taken,
    input  logic [ALEN-1:0] i_ex_address
);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] is_jump_q, is_jump_d;
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [TW-1:0]      tag_d    [ENTRIES];
    logic [ALEN-1:0]    target_q [ENTRIES];
    logic [ALEN-1:0]    target_d [ENTRIES];
    logic [1:0]         pht_q    [ENTRIES];
    logic [1:0]         pht_d    [ENTRIES];

    logic [IDX-1:0] fetch_idx, fetch_pht_idx, ex_idx, ex_pht_idx;
    logic [TW-1:0]  fetch_tag, ex_tag;
    logic           fetch_hit, ex_hit, upd;
    logic [1:0]     ex_cnt;
    logic           unused_pc_lsb;

    assign unused_pc_lsb = i_fetch_pc[0] ^ i_ex_pc[0];

`ifdef BP_GSHARE_EN
    logic [IDX-1:0] ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (upd && i_ex_branch)
            ghr_d = {ghr_q[IDX-2:0], i_ex_is_taken};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

    assign fetch_pht_idx = fetch_idx ^ ghr_q;
    assign ex_pht_idx    = ex_idx ^ ghr_q;
`else
    assign fetch_pht_idx = fetch_idx;
    assign ex_pht_idx    = ex_idx;
`endif

    always_comb begin
        fetch_idx        = i_fetch_pc[IDX:1];
        fetch_tag        = i_fetch_pc[ALEN-1:IDX+1];
        fetch_hit        = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        o_valid          = fetch_hit;
        o_branch_taken   = fetch_hit && (is_jump_q[fetch_idx] || pht_q[fetch_pht_idx][1]);
        o_target_address = fetch_hit ? target_q[fetch_idx] : '0;
    end

    // Next-state of the tables; at most one BTB entry and one counter change per cycle.
    always_comb begin
        valid_d   = valid_q;
        is_jump_d = is_jump_q;
        tag_d     = tag_q;
        target_d  = target_q;
        pht_d     = pht_q;
        ex_idx    = i_ex_pc[IDX:1];
        ex_tag    = i_ex_pc[ALEN-1:IDX+1];
        ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ex_cnt    = pht_q[ex_pht_idx];
        upd       = i_ex_valid && (i_ex_branch ^ i_ex_jump) && !i_rst;
        if (upd) begin
            if (i_ex_jump) begin
                valid_d[ex_idx]    = 1'b1;
                is_jump_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]      = ex_tag;
                target_d[ex_idx]   = i_ex_address;
                pht_d[ex_pht_idx]  = 2'd3;
            end else if (ex_hit) begin
                if (i_ex_is_taken) begin
                    pht_d[ex_pht_idx] = (ex_cnt == 2'd3) ? 2'd3 : ex_cnt + 2'd1;
                    target_d[ex_idx]  = i_ex_address;
                end else begin
                    pht_d[ex_pht_idx] = (ex_cnt == 2'd0) ? 2'd0 : ex_cnt - 2'd1;
                end
            end else if (i_ex_is_taken) begin
                valid_d[ex_idx]    = 1'b1;
                is_jump_d[ex_idx]  = 1'b0;
                tag_d[ex_idx]      = ex_tag;
                target_d[ex_idx]   = i_ex_address;
                pht_d[ex_pht_idx]  = 2'd2;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q   <= '0;
            is_jump_q <= '0;
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'd1;
        end else begin
            valid_q   <= valid_d;
            is_jump_q <= is_jump_d;
            pht_q     <= pht_d;
        end
    end

    // Tag and target contents are qualified by valid, so they carry no reset.
    always_ff @(posedge i_clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Directed-vector bench for riscv_core_branch_predictor (default build, ALEN=64, ENTRIES=16).
module tb_riscv_core_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] fetch_pc = '0;
    logic        valid, taken;
    logic [63:0] target;
    logic        ex_valid = 1'b0, ex_branch = 1'b0, ex_jump = 1'b0, ex_taken = 1'b0;
    logic [63:0] ex_pc = '0, ex_addr = '0;

    int vectors = 0;
    int miscompares = 0;

    riscv_core_branch_predictor #(.ALEN(64), .ENTRIES(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_fetch_pc(fetch_pc),
        .o_valid(valid), .o_branch_taken(taken), .o_target_address(target),
        .i_ex_valid(ex_valid), .i_ex_branch(ex_branch), .i_ex_jump(ex_jump),
        .i_ex_pc(ex_pc), .i_ex_is_taken(ex_taken), .i_ex_address(ex_addr)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [63:0] pc, input logic v,
                          input logic t, input logic [63:0] tgt);
        fetch_pc = pc;
        #1;
        check_vec({tag, ".valid"},  {63'd0, valid}, {63'd0, v});
        check_vec({tag, ".taken"},  {63'd0, taken}, {63'd0, t});
        check_vec({tag, ".target"}, target, tgt);
    endtask

    task automatic resolve(input logic br, input logic jmp, input logic tk,
                           input logic [63:0] pc, input logic [63:0] addr);
        @(negedge clk);
        ex_valid = 1'b1; ex_branch = br; ex_jump = jmp; ex_taken = tk;
        ex_pc = pc; ex_addr = addr;
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_taken = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        lookup("rst_hold", 64'h1000, 0, 0, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        lookup("empty", 64'h1000, 0, 0, 64'h0);

        // Taken branch allocates; lookup in the resolving cycle still sees the old table.
        @(negedge clk);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1;
        ex_pc = 64'h1000; ex_addr = 64'h2000;
        lookup("same_cycle", 64'h1000, 0, 0, 64'h0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0;
        lookup("alloc", 64'h1000, 1, 1, 64'h2000);

        // Counter walk: 2 -> 1 -> 0 -> 0 -> 1 -> 2 -> 3 -> 3 -> 2 -> 1
        resolve(1, 0, 0, 64'h1000, 64'h9990);
        lookup("nt1", 64'h1000, 1, 0, 64'h2000);
        resolve(1, 0, 0, 64'h1000, 64'h9990);
        lookup("nt2", 64'h1000, 1, 0, 64'h2000);
        resolve(1, 0, 0, 64'h1000, 64'h9990);
        lookup("nt_sat0", 64'h1000, 1, 0, 64'h2000);
        resolve(1, 0, 1, 64'h1000, 64'h2100);
        lookup("t_c1", 64'h1000, 1, 0, 64'h2100);
        resolve(1, 0, 1, 64'h1000, 64'h2100);
        lookup("t_c2", 64'h1000, 1, 1, 64'h2100);
        resolve(1, 0, 1, 64'h1000, 64'h2100);
        resolve(1, 0, 1, 64'h1000, 64'h2100);
        lookup("t_sat3", 64'h1000, 1, 1, 64'h2100);
        resolve(1, 0, 0, 64'h1000, 64'h9990);
        lookup("sat_nt_c2", 64'h1000, 1, 1, 64'h2100);
        resolve(1, 0, 0, 64'h1000, 64'h9990);
        lookup("sat_nt_c1", 64'h1000, 1, 0, 64'h2100);

        // Not-taken miss at an aliasing index neither allocates nor touches the counter.
        resolve(1, 0, 0, 64'h3000, 64'h3300);
        lookup("nt_miss", 64'h3000, 0, 0, 64'h0);
        lookup("nt_miss_keep", 64'h1000, 1, 0, 64'h2100);

        // Jumps overwrite on hit and evict an aliasing entry.
        resolve(0, 1, 0, 64'h1000, 64'h4000);
        lookup("jal_hit", 64'h1000, 1, 1, 64'h4000);
        resolve(0, 1, 0, 64'h1020, 64'h5000);
        lookup("jal_evicted", 64'h1000, 0, 0, 64'h0);
        lookup("jal_alias", 64'h1020, 1, 1, 64'h5000);

        // Illegal or idle strobes change nothing.
        resolve(1, 1, 1, 64'h1020, 64'h7777);
        lookup("both_set", 64'h1020, 1, 1, 64'h5000);
        @(negedge clk);
        ex_valid = 1'b0; ex_branch = 1'b1; ex_taken = 1'b1; ex_pc = 64'h1040; ex_addr = 64'h7777;
        @(posedge clk);
        #1;
        ex_branch = 1'b0; ex_taken = 1'b0;
        lookup("no_strobe", 64'h1040, 0, 0, 64'h0);

        // Taken then not-taken at another index: PHT entry tracks the BTB index.
        resolve(1, 0, 1, 64'h1006, 64'h6000);
        lookup("idx3_t", 64'h1006, 1, 1, 64'h6000);
        resolve(1, 0, 0, 64'h1006, 64'h6600);
        lookup("idx3_nt", 64'h1006, 1, 0, 64'h6000);

        // Asynchronous reset mid-sequence, with an update held across an edge during reset.
        @(negedge clk);
        #2;
        rst = 1'b1;
        lookup("async_rst_a", 64'h1020, 0, 0, 64'h0);
        lookup("async_rst_b", 64'h1006, 0, 0, 64'h0);
        @(negedge clk);
        ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 64'h1000; ex_addr = 64'h8000;
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_jump = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        lookup("rst_drop_upd", 64'h1000, 0, 0, 64'h0);
        resolve(0, 1, 0, 64'h1000, 64'h8000);
        lookup("post_rst_jal", 64'h1000, 1, 1, 64'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, expected finish before 50000");
        $fatal(1);
    end

endmodule
